// File: rtl/r22sdf_bf_stage.sv
// Radix-2^2 SDF butterfly stage: BF2I, trivial -j rotation and BF2II, each with
// its own feedback delay line, plus a sample counter re-aligned to the output.
module r22sdf_bf_stage #(
  parameter int DW        = 25,
  parameter int FFT_N     = 1024,
  parameter int FFT_NLOG2 = 10,
  parameter int STAGE     = 0,
  parameter int STAGES    = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic [FFT_NLOG2-1:0] cnt_i,
  output logic [FFT_NLOG2-1:0] cnt_o,
  input  logic signed [DW-1:0] x_re_i,
  input  logic signed [DW-1:0] x_im_i,
  output logic signed [DW-1:0] z_re_o,
  output logic signed [DW-1:0] z_im_o
);
  localparam int LOG2L = FFT_NLOG2 - 2 * STAGE;
  localparam int L     = FFT_N >> (2 * STAGE);
  localparam int D1    = L / 2;
  localparam int D2    = (STAGE == STAGES - 1) ? 1 : L / 4;
  localparam logic [FFT_NLOG2-1:0] HALF_L  = FFT_NLOG2'(D1);
  localparam logic [FFT_NLOG2-1:0] QUART_L = FFT_NLOG2'(D2);

  logic signed [DW-1:0] r_d1_re [D1];
  logic signed [DW-1:0] r_d1_im [D1];
  logic signed [DW-1:0] r_d2_re [D2];
  logic signed [DW-1:0] r_d2_im [D2];

  logic signed [DW-1:0] r_s1_re, r_s1_im;
  logic signed [DW-1:0] r_z_re, r_z_im;
  logic [FFT_NLOG2-1:0] r_cnt1, r_cnt2;

  logic [FFT_NLOG2-1:0] w_cnt_s;
  logic                 w_bf1_sum, w_rot, w_bf2_sum;
  logic signed [DW-1:0] w_bf1_re, w_bf1_im, w_fb1_re, w_fb1_im;
  logic signed [DW-1:0] w_rot_re, w_rot_im;
  logic signed [DW-1:0] w_bf2_re, w_bf2_im, w_fb2_re, w_fb2_im;

  // Second half of a block (BF2I) / second quarter of a half (BF2II) -> butterfly.
  assign w_bf1_sum = cnt_i[LOG2L-1];
  assign w_cnt_s   = cnt_i - HALF_L;
  assign w_rot     = w_cnt_s[LOG2L-1] & w_cnt_s[LOG2L-2];
  assign w_bf2_sum = r_cnt1[LOG2L-2];

  always_comb begin
    w_bf1_re = r_d1_re[D1-1];
    w_bf1_im = r_d1_im[D1-1];
    w_fb1_re = x_re_i;
    w_fb1_im = x_im_i;
    if (w_bf1_sum) begin
      w_bf1_re = r_d1_re[D1-1] + x_re_i;
      w_bf1_im = r_d1_im[D1-1] + x_im_i;
      w_fb1_re = r_d1_re[D1-1] - x_re_i;
      w_fb1_im = r_d1_im[D1-1] - x_im_i;
    end
  end

  assign w_rot_re = w_rot ? w_bf1_im  : w_bf1_re;
  assign w_rot_im = w_rot ? -w_bf1_re : w_bf1_im;

  always_comb begin
    w_bf2_re = r_d2_re[D2-1];
    w_bf2_im = r_d2_im[D2-1];
    w_fb2_re = r_s1_re;
    w_fb2_im = r_s1_im;
    if (w_bf2_sum) begin
      w_bf2_re = r_d2_re[D2-1] + r_s1_re;
      w_bf2_im = r_d2_im[D2-1] + r_s1_im;
      w_fb2_re = r_d2_re[D2-1] - r_s1_re;
      w_fb2_im = r_d2_im[D2-1] - r_s1_im;
    end
  end

  // Delay lines shift every cycle and are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    r_d1_re[0] <= w_fb1_re;
    r_d1_im[0] <= w_fb1_im;
    for (int i = 1; i < D1; i++) begin
      r_d1_re[i] <= r_d1_re[i-1];
      r_d1_im[i] <= r_d1_im[i-1];
    end
    r_d2_re[0] <= w_fb2_re;
    r_d2_im[0] <= w_fb2_im;
    for (int i = 1; i < D2; i++) begin
      r_d2_re[i] <= r_d2_re[i-1];
      r_d2_im[i] <= r_d2_im[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_re <= '0;
      r_s1_im <= '0;
      r_cnt1  <= '0;
      r_z_re  <= '0;
      r_z_im  <= '0;
      r_cnt2  <= '0;
    end else begin
      r_s1_re <= w_rot_re;
      r_s1_im <= w_rot_im;
      r_cnt1  <= w_cnt_s;
      r_z_re  <= w_bf2_re;
      r_z_im  <= w_bf2_im;
      r_cnt2  <= r_cnt1 - QUART_L;
    end
  end

  assign z_re_o = r_z_re;
  assign z_im_o = r_z_im;
  assign cnt_o  = r_cnt2;
endmodule

// File: tb/tb_r22sdf_bf_stage.sv
// Scoreboard bench for r22sdf_bf_stage: four configurations share one clock;
// expected outputs come from a direct 4-point DFT model over each block.
`timescale 1ns/1ps
module tb_r22sdf_bf_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: N=4 stage0, 1: N=16 stage1 (L=4), 2: DW=4 N=4, 3: N=16 stage0 (L=16)
  int cfg_l[4]   = '{4, 4, 4, 16};
  int cfg_n[4]   = '{4, 16, 4, 16};
  int cfg_dw[4]  = '{25, 25, 4, 25};
  int cfg_lat[4] = '{5, 5, 5, 14};
  int brev[4]    = '{0, 2, 1, 3};
  int cnt_var[4];

  logic [1:0] p0_cnt_i, p0_cnt_o;
  logic signed [24:0] p0_x_re, p0_x_im, p0_z_re, p0_z_im;
  logic [3:0] p1_cnt_i, p1_cnt_o;
  logic signed [24:0] p1_x_re, p1_x_im, p1_z_re, p1_z_im;
  logic [1:0] p2_cnt_i, p2_cnt_o;
  logic signed [3:0] p2_x_re, p2_x_im, p2_z_re, p2_z_im;
  logic [3:0] p3_cnt_i, p3_cnt_o;
  logic signed [24:0] p3_x_re, p3_x_im, p3_z_re, p3_z_im;

  r22sdf_bf_stage #(.DW(25), .FFT_N(4), .FFT_NLOG2(2), .STAGE(0), .STAGES(1)) u_dut0 (
    .clk_i(clk), .rst_n(rst_n), .cnt_i(p0_cnt_i), .cnt_o(p0_cnt_o),
    .x_re_i(p0_x_re), .x_im_i(p0_x_im), .z_re_o(p0_z_re), .z_im_o(p0_z_im));
  r22sdf_bf_stage #(.DW(25), .FFT_N(16), .FFT_NLOG2(4), .STAGE(1), .STAGES(2)) u_dut1 (
    .clk_i(clk), .rst_n(rst_n), .cnt_i(p1_cnt_i), .cnt_o(p1_cnt_o),
    .x_re_i(p1_x_re), .x_im_i(p1_x_im), .z_re_o(p1_z_re), .z_im_o(p1_z_im));
  r22sdf_bf_stage #(.DW(4), .FFT_N(4), .FFT_NLOG2(2), .STAGE(0), .STAGES(1)) u_dut2 (
    .clk_i(clk), .rst_n(rst_n), .cnt_i(p2_cnt_i), .cnt_o(p2_cnt_o),
    .x_re_i(p2_x_re), .x_im_i(p2_x_im), .z_re_o(p2_z_re), .z_im_o(p2_z_im));
  r22sdf_bf_stage #(.DW(25), .FFT_N(16), .FFT_NLOG2(4), .STAGE(0), .STAGES(2)) u_dut3 (
    .clk_i(clk), .rst_n(rst_n), .cnt_i(p3_cnt_i), .cnt_o(p3_cnt_o),
    .x_re_i(p3_x_re), .x_im_i(p3_x_im), .z_re_o(p3_z_re), .z_im_o(p3_z_im));

  typedef struct {
    int     dut;
    int     cyc;
    longint re;
    longint im;
    longint cnt;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic logic signed [63:0] obs_re(input int d);
    case (d)
      0: return p0_z_re;
      1: return p1_z_re;
      2: return p2_z_re;
      default: return p3_z_re;
    endcase
  endfunction

  function automatic logic signed [63:0] obs_im(input int d);
    case (d)
      0: return p0_z_im;
      1: return p1_z_im;
      2: return p2_z_im;
      default: return p3_z_im;
    endcase
  endfunction

  function automatic logic signed [63:0] obs_cnt(input int d);
    case (d)
      0: return {62'd0, p0_cnt_o};
      1: return {60'd0, p1_cnt_o};
      2: return {62'd0, p2_cnt_o};
      default: return {60'd0, p3_cnt_o};
    endcase
  endfunction

  function automatic longint wrapv(input longint v, input int w);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
    return m;
  endfunction

  task automatic set_x(input int d, input longint re, input longint im);
    case (d)
      0: begin p0_x_re = 25'(re); p0_x_im = 25'(im); end
      1: begin p1_x_re = 25'(re); p1_x_im = 25'(im); end
      2: begin p2_x_re = 4'(re);  p2_x_im = 4'(im);  end
      default: begin p3_x_re = 25'(re); p3_x_im = 25'(im); end
    endcase
  endtask

  // All counters run every cycle so every stage sees a continuous stream.
  task automatic tick();
    p0_cnt_i = 2'(cnt_var[0]);
    p1_cnt_i = 4'(cnt_var[1]);
    p2_cnt_i = 2'(cnt_var[2]);
    p3_cnt_i = 4'(cnt_var[3]);
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) cnt_var[d] = (cnt_var[d] + 1) % cfg_n[d];
  endtask

  task automatic run_block(input int d, input longint bre[16], input longint bim[16]);
    int L;
    int qq;
    int base;
    int kk;
    int n;
    int e;
    longint sre;
    longint sim;
    sb_t ent;
    L  = cfg_l[d];
    qq = L / 4;
    while (cnt_var[d] % L != 0) tick();
    base = cyc;
    for (int q = 0; q < L; q++) begin
      kk  = brev[q / qq];
      n   = q % qq;
      sre = 0;
      sim = 0;
      for (int m = 0; m < 4; m++) begin
        e = (m * kk) % 4;
        case (e)
          0: begin sre += bre[n+m*qq]; sim += bim[n+m*qq]; end
          1: begin sre += bim[n+m*qq]; sim -= bre[n+m*qq]; end
          2: begin sre -= bre[n+m*qq]; sim -= bim[n+m*qq]; end
          default: begin sre -= bim[n+m*qq]; sim += bre[n+m*qq]; end
        endcase
      end
      ent.dut = d;
      ent.cyc = base + q + cfg_lat[d];
      ent.re  = wrapv(sre, cfg_dw[d]);
      ent.im  = wrapv(sim, cfg_dw[d]);
      ent.cnt = longint'((cnt_var[d] + q) % cfg_n[d]);
      sb_q.push_back(ent);
    end
    for (int q = 0; q < L; q++) begin
      set_x(d, bre[q], bim[q]);
      tick();
    end
    set_x(d, 0, 0);
  endtask

  task automatic blk4(input int d, input longint x0, input longint x1,
                      input longint x2, input longint x3);
    longint bre[16];
    longint bim[16];
    for (int i = 0; i < 16; i++) begin
      bre[i] = 0;
      bim[i] = 0;
    end
    bre[0] = x0; bre[1] = x1; bre[2] = x2; bre[3] = x3;
    run_block(d, bre, bim);
  endtask

  task automatic blk_rand(input int d);
    longint bre[16];
    longint bim[16];
    for (int i = 0; i < 16; i++) begin
      bre[i] = longint'($urandom_range(4000)) - 2000;
      bim[i] = longint'($urandom_range(4000)) - 2000;
    end
    run_block(d, bre, bim);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64 && sb_q.size() > 0; i++) tick();
    check_val("sb_drain", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cyc < cyc) begin
        check_val($sformatf("d%0d_late", mon_e.dut), cyc, mon_e.cyc);
      end else begin
        check_val($sformatf("d%0d_c%0d_re", mon_e.dut, mon_e.cnt), obs_re(mon_e.dut), mon_e.re);
        check_val($sformatf("d%0d_c%0d_im", mon_e.dut, mon_e.cnt), obs_im(mon_e.dut), mon_e.im);
        check_val($sformatf("d%0d_c%0d_cnt", mon_e.dut, mon_e.cnt), obs_cnt(mon_e.dut), mon_e.cnt);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      cnt_var[d] = 0;
      set_x(d, 0, 0);
    end
    repeat (3) tick();
    for (int d = 0; d < 4; d++) begin
      cnt_var[d] = 0;
      check_val($sformatf("rst_d%0d_re", d), obs_re(d), 0);
      check_val($sformatf("rst_d%0d_im", d), obs_im(d), 0);
      check_val($sformatf("rst_d%0d_cnt", d), obs_cnt(d), 0);
    end
    rst_n = 1'b1;

    blk4(0, 1, 2, 3, 4);
    repeat (3) blk4(0, 5, 5, 5, 5);
    blk4(0, 0, 1, 0, 0);
    blk4(0, 1, 0, 0, 0);

    blk4(1, 1, 2, 3, 4);
    blk4(1, 4, 3, 2, 1);
    blk4(1, 1, 2, 3, 4);
    blk4(1, 4, 3, 2, 1);
    blk4(1, -3, 7, 0, 2);

    blk4(2, 7, 7, 7, 7);
    blk4(2, 7, 7, 7, 7);
    blk4(2, -8, 3, -5, 6);

    repeat (3) blk_rand(3);
    wait_drain();

    // Reset in the middle of a block: outputs must clear without a clock edge.
    blk4(0, 1, 2, 3, 4);
    set_x(0, 9, 0);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    sb_q.delete();
    check_val("midrst_re", obs_re(0), 0);
    check_val("midrst_im", obs_im(0), 0);
    check_val("midrst_cnt", obs_cnt(0), 0);
    set_x(0, 0, 0);
    tick();
    tick();
    for (int d = 0; d < 4; d++) cnt_var[d] = 0;
    rst_n = 1'b1;
    blk4(0, 1, 2, 3, 4);
    blk4(0, 4, 3, 2, 1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
